// File: rtl/mux2_stream_arbiter.sv
// Two-input round-robin packet arbiter feeding a registered 2:1 mux.
// Packets hold the grant until their last beat; the output register is one entry deep.
module mux2_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] f_data,
    output logic             f_valid,
    output logic             f_last,
    input  logic             f_ready,
    output logic             sel,
    output logic [1:0]       fsm_state
);

    // Handshake: a beat moves on a port at a rising edge where valid & ready are both
    // high; producers hold data/last/valid stable until accepted, and a ready never
    // looks at its own port's valid.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   prio;
    logic   prio_next;
    logic   load_ok;
    logic   a_take;
    logic   b_take;

    assign load_ok   = ~f_valid | f_ready;
    assign a_take    = a_valid & a_ready;
    assign b_take    = b_valid & b_ready;
    assign fsm_state = state;

    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        state_next = state;
        prio_next  = prio;

        case (state)
            IDLE: begin
                a_ready = rst_n & load_ok & (~b_valid | prio);
                b_ready = rst_n & load_ok & (~a_valid | ~prio);
            end
            LOCK_A:  a_ready = rst_n & load_ok;
            LOCK_B:  b_ready = rst_n & load_ok;
            default: state_next = IDLE;
        endcase

        // A completed packet hands the tie-break to the other port.
        if (a_take) begin
            state_next = a_last ? IDLE : LOCK_A;
            if (a_last) prio_next = 1'b0;
        end else if (b_take) begin
            state_next = b_last ? IDLE : LOCK_B;
            if (b_last) prio_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b1;
            f_valid <= 1'b0;
            f_data  <= '0;
            f_last  <= 1'b0;
            sel     <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            if (a_take || b_take) begin
                f_valid <= 1'b1;
                f_data  <= a_take ? a_data : b_data;
                f_last  <= a_take ? a_last : b_last;
                sel     <= a_take;
            end else if (f_ready) begin
                f_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus randomized packet traffic,
// checked cycle by cycle against a packet-level arbitration model and an output scoreboard.
module tb_mux2_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data, b_data, f_data;
    logic       a_valid, a_last, a_ready;
    logic       b_valid, b_last, b_ready;
    logic       f_valid, f_last, f_ready, sel;
    logic [1:0] fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the output path, who wins the next tie, output register.
    int         m_owner;   // 0 none, 1 A mid-packet, 2 B mid-packet
    bit         m_fav_a;
    bit         m_fv, m_fl, m_sel;
    logic [7:0] m_fd;
    bit         a_acc, b_acc;
    int         a_hold, b_hold;
    bit         rnd_gap;

    logic [8:0] a_q[$], b_q[$];
    logic [9:0] exp_q[$], out_log[$], exp_l[$];

    mux2_stream_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .f_data(f_data), .f_valid(f_valid), .f_last(f_last), .f_ready(f_ready),
        .sel(sel), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_fav_a = 1'b1;
        m_fv = 1'b0; m_fl = 1'b0; m_sel = 1'b0; m_fd = 8'h00;
        a_acc = 1'b0; b_acc = 1'b0;
        a_hold = 0; b_hold = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; f_ready = 1'b1;
        a_q.delete(); b_q.delete();
        #1;
        model_reset();
        check("rst_f_valid", f_valid, 0);
        check("rst_f_data", f_data, 8'h00);
        check("rst_f_last", f_last, 0);
        check("rst_sel", sel, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_state", fsm_state, 0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_hold_f_valid", f_valid, 0);
        rst_n = 1'b1;
    endtask

    task automatic drive_producers();
        if (a_valid && a_acc) a_valid = 1'b0;
        if (b_valid && b_acc) b_valid = 1'b0;
        a_acc = 1'b0; b_acc = 1'b0;
        if (!a_valid && a_q.size() > 0 && a_hold == 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
            {a_last, a_data} = a_q.pop_front();
            a_valid = 1'b1;
        end
        if (!b_valid && b_q.size() > 0 && b_hold == 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
            {b_last, b_data} = b_q.pop_front();
            b_valid = 1'b1;
        end
        if (a_hold > 0) a_hold--;
        if (b_hold > 0) b_hold--;
    endtask

    task automatic cycle(input bit fr);
        bit space, ea, eb, ta, tb;
        f_ready = fr;
        drive_producers();
        @(negedge clk);
        space = !m_fv || fr;
        case (m_owner)
            1:       begin ea = space; eb = 1'b0; end
            2:       begin ea = 1'b0;  eb = space; end
            default: begin
                ea = space && (!b_valid || m_fav_a);
                eb = space && (!a_valid || !m_fav_a);
            end
        endcase
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        if (f_valid === 1'b1 && f_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            out_log.push_back({sel, f_last, f_data});
            if (exp_q.size() != 0) check("sb_beat", {sel, f_last, f_data}, exp_q.pop_front());
        end
        ta = a_valid && ea;
        tb = b_valid && eb;
        @(posedge clk);
        #1;
        if (ta) begin
            m_fv = 1'b1; m_fd = a_data; m_fl = a_last; m_sel = 1'b1;
            m_owner = a_last ? 0 : 1;
            if (a_last) m_fav_a = 1'b0;
            exp_q.push_back({1'b1, a_last, a_data});
        end else if (tb) begin
            m_fv = 1'b1; m_fd = b_data; m_fl = b_last; m_sel = 1'b0;
            m_owner = b_last ? 0 : 2;
            if (b_last) m_fav_a = 1'b1;
            exp_q.push_back({1'b0, b_last, b_data});
        end else if (fr) begin
            m_fv = 1'b0;
        end
        a_acc = ta; b_acc = tb;
        check("f_valid", f_valid, m_fv);
        check("f_data", f_data, m_fd);
        check("f_last", f_last, m_fl);
        check("sel", sel, m_sel);
        check("state", fsm_state, m_owner[1:0]);
    endtask

    task automatic run_drain(input string tag, input int max_cyc, input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            done = a_q.size() == 0 && b_q.size() == 0 && (!a_valid || a_acc)
                   && (!b_valid || b_acc) && !m_fv;
        end
        check({tag, "_drain"}, done, 1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, out_log.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < out_log.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_log[i], exp_l[i]);
        out_log.delete();
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00; f_ready = 1'b1;
        rnd_gap = 1'b0;
        model_reset();

        // Reset values, then idle cycles stay quiet
        do_reset();
        repeat (3) cycle(1'b1);
        out_log.delete();

        // Tie round-robin
        a_q = '{{1'b1, 8'h11}, {1'b1, 8'h12}};
        b_q = '{{1'b1, 8'h21}, {1'b1, 8'h22}};
        run_drain("tie", 20, 1'b0);
        exp_l = '{{1'b1, 1'b1, 8'h11}, {1'b0, 1'b1, 8'h21}, {1'b1, 1'b1, 8'h12}, {1'b0, 1'b1, 8'h22}};
        check_log("tie");

        // Packet lock: B arrives one cycle after A starts its 3-beat packet
        a_q = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b1, 8'hA2}};
        b_q = '{{1'b1, 8'hB0}};
        b_hold = 1;
        run_drain("lock", 20, 1'b0);
        exp_l = '{{1'b1, 1'b0, 8'hA0}, {1'b1, 1'b0, 8'hA1}, {1'b1, 1'b1, 8'hA2}, {1'b0, 1'b1, 8'hB0}};
        check_log("lock");

        // Backpressure: 0x11 held for 4 stalled cycles while 0x33 waits
        a_q = '{{1'b1, 8'h11}, {1'b1, 8'h33}};
        cycle(1'b0);
        repeat (4) cycle(1'b0);
        check("bp_hold_data", f_data, 8'h11);
        check("bp_a_ready", a_ready, 0);
        run_drain("bp", 20, 1'b0);
        exp_l = '{{1'b1, 1'b1, 8'h11}, {1'b1, 1'b1, 8'h33}};
        check_log("bp");

        // Single-port stream on B with prio favouring A
        do_reset();
        b_q = '{{1'b1, 8'h01}, {1'b1, 8'h02}, {1'b1, 8'h03}, {1'b1, 8'h04}};
        run_drain("single", 20, 1'b0);
        exp_l = '{{1'b0, 1'b1, 8'h01}, {1'b0, 1'b1, 8'h02}, {1'b0, 1'b1, 8'h03}, {1'b0, 1'b1, 8'h04}};
        check_log("single");

        // Reset mid-packet
        a_q = '{{1'b0, 8'hC0}, {1'b0, 8'hC1}, {1'b1, 8'hC2}};
        cycle(1'b1);
        check("midpkt_locked", fsm_state, 2'd1);
        do_reset();
        out_log.delete();
        check("midpkt_state_idle", fsm_state, 2'd0);
        b_q = '{{1'b1, 8'h55}};
        run_drain("midpkt", 20, 1'b0);
        exp_l = '{{1'b0, 1'b1, 8'h55}};
        check_log("midpkt");

        // Randomized packet traffic with gaps and random backpressure
        rnd_gap = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len_a = $urandom_range(1, 4);
            int len_b = $urandom_range(1, 4);
            for (int k = 0; k < len_a; k++) a_q.push_back({k == len_a - 1, 8'($urandom)});
            for (int k = 0; k < len_b; k++) b_q.push_back({k == len_b - 1, 8'($urandom)});
        end
        run_drain("rand", 4000, 1'b1);
        check("rand_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input round-robin packet arbiter that drives the select of the 2:1 data mux and registers the muxed result. It sits directly upstream of the output consumer: two producer streams (A, B) compete, and the winner's beats pass through a select-driven 2:1 mux into a one-entry output register. The mux convention `sel = 1` → A and `sel = 0` → B is kept. Multi-beat packets hold the grant until their last beat.

## Interface
- `WIDTH`, 8, data width of each stream.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset.
  - Asynchronous, active-low.
  - Single clock domain.
- `a_data`  in  WIDTH  stream A data.
- `a_valid`  in  1  stream A beat valid.
- `a_last`  in  1  stream A last beat of packet.
- `a_ready`  out  1  stream A beat accepted this cycle when high with `a_valid`.
- `b_data`, `b_valid`, `b_last`, `b_ready`: same as A, for stream B.
- `f_data`  out  WIDTH  registered muxed data.
- `f_valid`  out  1  output beat valid.
- `f_last`  out  1  registered last flag.
- `f_ready`  in  1  consumer accepts output beat.
- `sel`  out  1  source of the beat held in the output register (1 = A, 0 = B).

## Operation
- **Handshake:** a transfer occurs on any port when valid and ready are both high at a rising edge. A producer holds data, last and valid stable until its beat is accepted.
- **Output register load enable:** `load_ok = ~f_valid | f_ready`.
- **States:**
  - `IDLE`: no packet in progress.
  - `LOCK_A`: packet from A in progress.
  - `LOCK_B`: packet from B in progress.
- **Priority pointer `prio`:** 1 means A wins a tie; reset value 1.
- **Ready equations:**
  - In IDLE: `a_ready = load_ok & (~b_valid | prio)` and `b_ready = load_ok & (~a_valid | ~prio)`.
  - In `LOCK_A`: `a_ready = load_ok` and `b_ready = 0`. `LOCK_B` mirrors this.
  - A port's ready never depends on that port's own valid.
  - At most one of `a_ready & a_valid` and `b_ready & b_valid` is high in any cycle.
- **Accepting a beat from port X:**
  - `f_data`/`f_last` load X's data/last, `f_valid` is set to 1, and `sel` is set to X.
  - If `last = 0`, the next state is `LOCK_X`.
  - If `last = 1`, the next state is IDLE and `prio` is set to favour the other port.
  - A single-beat packet (`last = 1` accepted in IDLE) stays in IDLE and still flips `prio` to the other port.
- **Clearing the output:** if `f_valid & f_ready` and no new beat is loaded, `f_valid` goes to 0. `f_data`, `f_last` and `sel` hold their values.
- **While locked:** the other port's valid is ignored, and it waits with no loss of data.
- **Reset (`rst_n` low):**
  - Effect is immediate, regardless of clock.
  - `f_valid = 0`, `f_data = 0`, `f_last = 0`, `sel = 0`, state = IDLE, `prio = 1`.
  - Reset mid-packet abandons the packet. No partial-packet recovery is done; after reset, arbitration restarts fresh.
  - `a_ready`/`b_ready` are 0 while `rst_n` is low.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `f_*` after edge N.
- Throughput is 1 beat per cycle when `f_ready` is held high.
- Backpressure: with `f_valid = 1` and `f_ready = 0`, both readies are 0 in the same cycle (combinational path from `f_ready` to `a_ready`/`b_ready`).
- Simultaneous `f_ready` and a new accept: the register is overwritten in the same edge, giving no bubble.
- Output register contents change only on an accept edge or a reset.

## Test plan
- **Reset values:** assert `rst_n = 0` mid-cycle → `f_valid = 0`, `f_data = 0x00`, `f_last = 0`, `sel = 0` immediately, without waiting for a clock edge. Release reset, then check the idle outputs stay at those values.
- **Tie round-robin:**
  - Stimulus: A and B both valid with `last = 1`, A sending 0x11, 0x12 and B sending 0x21, 0x22, with `f_ready = 1`.
  - Required response: output order is 0x11 (`sel = 1`), 0x21 (`sel = 0`), 0x12, 0x22, one beat per cycle.
- **Packet lock:**
  - Stimulus: A sends 3 beats 0xA0, 0xA1, 0xA2, with `last` set on 0xA2. B is valid with 0xB0 from cycle 1.
  - Required response: `b_ready = 0` until 0xA2 is accepted, and 0xB0 appears on the next cycle after 0xA2.
- **Backpressure:**
  - Stimulus: `f_ready = 0` for 4 cycles while `f_valid = 1` holding 0x11, with A valid on 0x33.
  - Required response: `f_data` holds 0x11, and `a_ready = 0`.
  - On release: 0x33 is loaded at the same edge that 0x11 is consumed, with no idle cycle between them.
- **Single-port stream:**
  - Stimulus: only B valid, sending 0x01..0x04 with `last = 1` each.
  - Required response: `b_ready = 1` every cycle even though `prio = 1`, and the output is 0x01..0x04 back-to-back with `sel = 0`.
- **Reset mid-packet:**
  - Stimulus: assert `rst_n` low after A's first beat of a 3-beat packet, then release with B valid on 0x55.
  - Required response: state is IDLE after release, B is granted, and 0x55 appears with `sel = 0`.
